// File: rtl/bram_sdp_arbiter_if.sv
// ---------------------------------------------------------------------------
// bram_sdp_arbiter_if
//
// Purpose:
//   Bundles the two-requester client bus of bram_sdp_arbiter. Each vector
//   carries both requesters side by side: bit i / slice i belongs to
//   requester i.
//
// Signals:
//   wvalid    [1:0]           write request, one bit per requester
//   wready    [1:0]           write grant; transfer on wvalid[i] & wready[i]
//   waddr     [2*AWIDTH-1:0]  write address, requester i at [i*AWIDTH +: AWIDTH]
//   wdata     [2*DWIDTH-1:0]  write data, requester i at [i*DWIDTH +: DWIDTH]
//   rvalid    [1:0]           read request, one bit per requester
//   rready    [1:0]           read grant
//   raddr     [2*AWIDTH-1:0]  read address, requester i at [i*AWIDTH +: AWIDTH]
//   rsp_valid [1:0]           one-cycle read-response strobe per requester
//   rsp_data  [DWIDTH-1:0]    shared read data, qualified by rsp_valid
//
// Modports:
//   master : client side (drives requests, receives grants and responses)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface bram_sdp_arbiter_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 36
);

    logic [1:0]          wvalid;
    logic [1:0]          wready;
    logic [2*AWIDTH-1:0] waddr;
    logic [2*DWIDTH-1:0] wdata;

    logic [1:0]          rvalid;
    logic [1:0]          rready;
    logic [2*AWIDTH-1:0] raddr;

    logic [1:0]          rsp_valid;
    logic [DWIDTH-1:0]   rsp_data;

    modport master (
        output wvalid, waddr, wdata,
        output rvalid, raddr,
        input  wready, rready,
        input  rsp_valid, rsp_data
    );

    modport slave (
        input  wvalid, waddr, wdata,
        input  rvalid, raddr,
        output wready, rready,
        output rsp_valid, rsp_data
    );

endinterface

// File: rtl/bram_sdp_arbiter.sv
// ---------------------------------------------------------------------------
// bram_sdp_arbiter
//
// Purpose:
//   Shares one simple-dual-port block RAM (1-cycle registered read) between
//   two requesters. The write and read channels each have their own
//   round-robin arbiter, so the RAM can take one write and one read every
//   cycle. With INIT_CLEAR=1 the whole array is swept to zero after reset
//   before any requester is served.
//
// Ports:
//   clk          in   sole clock, rising edge, shared with the RAM
//   rst_n        in   synchronous active-low reset
//   bus          slave modport of bram_sdp_arbiter_if (client requests,
//                grants and read responses)
//   init_done_o  out  high once the zero sweep has finished
//                     (constant high when INIT_CLEAR=0)
//   ram_wce_o    out  RAM write enable
//   ram_wa_o     out  RAM write address
//   ram_wd_o     out  RAM write data
//   ram_rce_o    out  RAM read enable
//   ram_ra_o     out  RAM read address
//   ram_rq_i     in   RAM read data (valid the cycle after ram_rce_o)
// ---------------------------------------------------------------------------
module bram_sdp_arbiter #(
    parameter int AWIDTH     = 10,
    parameter int DWIDTH     = 36,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    bram_sdp_arbiter_if.slave  bus,
    output logic               init_done_o,
    output logic               ram_wce_o,
    output logic [AWIDTH-1:0]  ram_wa_o,
    output logic [DWIDTH-1:0]  ram_wd_o,
    output logic               ram_rce_o,
    output logic [AWIDTH-1:0]  ram_ra_o,
    input  logic [DWIDTH-1:0]  ram_rq_i
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AWIDTH-1:0] LAST_ADDR = '1;
    localparam state_t            RESET_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;

    state_t              state_q;
    logic [AWIDTH-1:0]   sweepCnt_q;
    logic [AWIDTH-1:0]   sweepCnt_d;
    logic                initDone_q;
    logic                wPtr_q;
    logic                wPtr_d;
    logic                rPtr_q;
    logic                rPtr_d;
    logic [1:0]          rspValid_q;
    logic [1:0]          rspValid_d;

    logic                running;
    logic                sweeping;
    logic [1:0]          wGrant;
    logic [1:0]          rGrant;

    logic [AWIDTH-1:0]   wAddr0;
    logic [AWIDTH-1:0]   wAddr1;
    logic [DWIDTH-1:0]   wData0;
    logic [DWIDTH-1:0]   wData1;
    logic [AWIDTH-1:0]   rAddr0;
    logic [AWIDTH-1:0]   rAddr1;

    // Round-robin pick between two requesters. The pointer holds the index
    // of the requester granted last on this channel; on contention the other
    // one wins. A lone requester is granted every cycle.
    function automatic logic [1:0] pickGrant(input logic [1:0] valid,
                                             input logic       lastGrant);
        logic [1:0] grant;
        if (valid == 2'b11) begin
            grant = lastGrant ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
        return grant;
    endfunction

    // Split the packed requester buses into per-requester fields.
    assign wAddr0 = bus.waddr[0*AWIDTH +: AWIDTH];
    assign wAddr1 = bus.waddr[1*AWIDTH +: AWIDTH];
    assign wData0 = bus.wdata[0*DWIDTH +: DWIDTH];
    assign wData1 = bus.wdata[1*DWIDTH +: DWIDTH];
    assign rAddr0 = bus.raddr[0*AWIDTH +: AWIDTH];
    assign rAddr1 = bus.raddr[1*AWIDTH +: AWIDTH];

    // Grants and RAM enables are forced off while rst_n is low, so nothing
    // reaches the RAM during reset even though state_q still holds its
    // pre-reset value for that cycle.
    assign running  = rst_n && (state_q == ST_RUN);
    assign sweeping = rst_n && (state_q == ST_INIT);

    // Both arbiters look only at valids and their own pointer, so there is
    // no path from ram_rq_i to any ready.
    always_comb begin
        wGrant = 2'b00;
        rGrant = 2'b00;
        if (running) begin
            wGrant = pickGrant(bus.wvalid, wPtr_q);
            rGrant = pickGrant(bus.rvalid, rPtr_q);
        end
    end

    assign bus.wready = wGrant;
    assign bus.rready = rGrant;

    // Write-port mux: the sweep owns the port during INIT, otherwise the
    // granted requester's address and data are steered through.
    always_comb begin
        ram_wce_o = 1'b0;
        ram_wa_o  = wAddr0;
        ram_wd_o  = wData0;
        if (sweeping) begin
            ram_wce_o = 1'b1;
            ram_wa_o  = sweepCnt_q;
            ram_wd_o  = '0;
        end else begin
            ram_wce_o = |wGrant;
            if (wGrant[1]) begin
                ram_wa_o = wAddr1;
                ram_wd_o = wData1;
            end
        end
    end

    // Read-port mux: the read port is idle during the sweep because no
    // read grant is issued there.
    always_comb begin
        ram_rce_o = |rGrant;
        ram_ra_o  = rGrant[1] ? rAddr1 : rAddr0;
    end

    // Next-state values for the pointers, the response strobe and the sweep
    // counter. Pointers move only when their channel actually grants.
    always_comb begin
        wPtr_d     = (|wGrant) ? wGrant[1] : wPtr_q;
        rPtr_d     = (|rGrant) ? rGrant[1] : rPtr_q;
        rspValid_d = rGrant;
        sweepCnt_d = sweepCnt_q;
        if (state_q == ST_INIT) begin
            sweepCnt_d = sweepCnt_q + 1'b1;
        end
    end

    // Main FSM: INIT walks the sweep counter over every address and hands
    // over to RUN right after the last address has been written. The
    // response strobe is the read grant delayed by one cycle, lining up
    // with the RAM's registered read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            sweepCnt_q <= '0;
            initDone_q <= !INIT_CLEAR;
            wPtr_q     <= 1'b1;
            rPtr_q     <= 1'b1;
            rspValid_q <= 2'b00;
        end else begin
            wPtr_q     <= wPtr_d;
            rPtr_q     <= rPtr_d;
            rspValid_q <= rspValid_d;
            sweepCnt_q <= sweepCnt_d;
            case (state_q)
                ST_INIT: begin
                    if (sweepCnt_q == LAST_ADDR) begin
                        state_q    <= ST_RUN;
                        initDone_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= RESET_STATE;
                end
            endcase
        end
    end

    // Read data comes straight from the RAM; rsp_valid says who owns it.
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_data  = ram_rq_i;
    assign init_done_o   = initDone_q;

endmodule

// File: tb/tb_bram_sdp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_sdp_arbiter
//
// Directed bench for bram_sdp_arbiter with AWIDTH=4, DWIDTH=36,
// INIT_CLEAR=1, attached to a behavioural SDP RAM with a 1-cycle
// registered read and read-old-data on a same-address collision.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_bram_sdp_arbiter;

    localparam int AW = 4;
    localparam int DW = 36;

    logic          clk;
    logic          rst_n;
    logic          initDone;
    logic          ramWce;
    logic [AW-1:0] ramWa;
    logic [DW-1:0] ramWd;
    logic          ramRce;
    logic [AW-1:0] ramRa;
    logic [DW-1:0] ramRq;

    logic [DW-1:0] ramMem [16] = '{default: 36'hBADBADBAD};
    logic [DW-1:0] expMem [16];

    int vectorCount;
    int missCount;

    bram_sdp_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    bram_sdp_arbiter #(
        .AWIDTH    (AW),
        .DWIDTH    (DW),
        .INIT_CLEAR(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .init_done_o(initDone),
        .ram_wce_o  (ramWce),
        .ram_wa_o   (ramWa),
        .ram_wd_o   (ramWd),
        .ram_rce_o  (ramRce),
        .ram_ra_o   (ramRa),
        .ram_rq_i   (ramRq)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM_SDP: registered read, write lands at the same edge,
    // so a same-address read in that cycle returns the old word.
    always @(posedge clk) begin
        if (ramRce) ramRq <= ramMem[ramRa];
        if (ramWce) ramMem[ramWa] <= ramWd;
    end

    // Count one comparison and report it if it misses.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's worth of inputs after the falling edge, then let
    // combinational outputs settle before the caller samples.
    task automatic applyStimulus(input logic rstN,
                                 input logic [1:0] wv, input logic [1:0] rv,
                                 input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                                 input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                                 input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        @(negedge clk);
        rst_n      = rstN;
        bus.wvalid = wv;
        bus.rvalid = rv;
        bus.waddr  = {wa1, wa0};
        bus.wdata  = {wd1, wd0};
        bus.raddr  = {ra1, ra0};
        #1;
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        rst_n       = 1'b0;
        bus.wvalid  = 2'b00;
        bus.rvalid  = 2'b00;
        bus.waddr   = '0;
        bus.wdata   = '0;
        bus.raddr   = '0;

        // Reset with requests asserted: everything must stay quiet.
        applyStimulus(1'b0, 2'b11, 2'b11, 4'd1, 4'd2, 36'h5, 36'h6, 4'd3, 4'd4);
        checkOutput("rstWready", bus.wready, 2'b00);
        checkOutput("rstRready", bus.rready, 2'b00);
        checkOutput("rstWce", ramWce, 1'b0);
        checkOutput("rstRce", ramRce, 1'b0);
        applyStimulus(1'b0, 2'b11, 2'b11, 4'd1, 4'd2, 36'h5, 36'h6, 4'd3, 4'd4);
        checkOutput("rstRspValid", bus.rsp_valid, 2'b00);
        checkOutput("rstInitDone", initDone, 1'b0);

        // Zero sweep over 16 addresses with requests held off by the FSM.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 2'b11, 2'b11, 4'd1, 4'd2, 36'h5, 36'h6, 4'd3, 4'd4);
            checkOutput("sweepWce", ramWce, 1'b1);
            checkOutput("sweepWa", ramWa, i[AW-1:0]);
            checkOutput("sweepWd", ramWd, 36'h0);
            checkOutput("sweepWready", bus.wready, 2'b00);
            checkOutput("sweepRready", bus.rready, 2'b00);
            checkOutput("sweepRce", ramRce, 1'b0);
            checkOutput("sweepInitDone", initDone, 1'b0);
        end
        for (int i = 0; i < 16; i++) expMem[i] = '0;

        // Readback of every address by requester 0; cycle 16 is the first
        // grantable cycle and init_done must already be high there.
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin
                applyStimulus(1'b1, 2'b00, 2'b01, 4'd0, 4'd0, 36'h0, 36'h0, k[AW-1:0], 4'd0);
                checkOutput("rbRready", bus.rready, 2'b01);
                checkOutput("rbRa", ramRa, k[AW-1:0]);
                checkOutput("rbInitDone", initDone, 1'b1);
            end else begin
                applyStimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd0);
                checkOutput("rbWce", ramWce, 1'b0);
            end
            if (k > 0) begin
                checkOutput("rbRspValid", bus.rsp_valid, 2'b01);
                checkOutput("rbRspData", bus.rsp_data, expMem[k-1]);
            end
        end

        // Both writers contend for six cycles: requester 0 first, then alternate.
        for (int j = 0; j < 6; j++) begin
            logic [1:0]    expGrant;
            logic [AW-1:0] expAddr;
            logic [DW-1:0] expData;
            expGrant = (j % 2 == 0) ? 2'b01 : 2'b10;
            expAddr  = (j % 2 == 0) ? AW'(j) : AW'(8 + j);
            expData  = (j % 2 == 0) ? DW'(36'h100 + j) : DW'(36'h200 + j);
            applyStimulus(1'b1, 2'b11, 2'b00, AW'(j), AW'(8 + j),
                          DW'(36'h100 + j), DW'(36'h200 + j), 4'd0, 4'd0);
            checkOutput("wcWready", bus.wready, expGrant);
            checkOutput("wcWa", ramWa, expAddr);
            checkOutput("wcWd", ramWd, expData);
            expMem[expAddr] = expData;
        end

        // Requester 1 writes 0x5A5 to addr 3 and reads it back.
        applyStimulus(1'b1, 2'b10, 2'b00, 4'd0, 4'd3, 36'h0, 36'h5A5, 4'd0, 4'd0);
        checkOutput("r1Wready", bus.wready, 2'b10);
        checkOutput("r1Wa", ramWa, 4'd3);
        checkOutput("r1Wd", ramWd, 36'h5A5);
        expMem[3] = 36'h5A5;
        applyStimulus(1'b1, 2'b00, 2'b10, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd3);
        checkOutput("r1Rready", bus.rready, 2'b10);
        checkOutput("r1Rce", ramRce, 1'b1);
        checkOutput("r1Ra", ramRa, 4'd3);
        checkOutput("r1NoEarlyRsp", bus.rsp_valid, 2'b00);
        applyStimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd0);
        checkOutput("r1RspValid", bus.rsp_valid, 2'b10);
        checkOutput("r1RspData", bus.rsp_data, 36'h5A5);
        applyStimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd0);
        checkOutput("r1RspOnce", bus.rsp_valid, 2'b00);

        // Same-cycle write and read of addr 7 returns the old word.
        applyStimulus(1'b1, 2'b01, 2'b00, 4'd7, 4'd0, 36'h0AA, 36'h0, 4'd0, 4'd0);
        checkOutput("colPreWready", bus.wready, 2'b01);
        expMem[7] = 36'h0AA;
        applyStimulus(1'b1, 2'b01, 2'b10, 4'd7, 4'd0, 36'h123, 36'h0, 4'd0, 4'd7);
        checkOutput("colWready", bus.wready, 2'b01);
        checkOutput("colRready", bus.rready, 2'b10);
        applyStimulus(1'b1, 2'b00, 2'b10, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd7);
        checkOutput("colRspValid", bus.rsp_valid, 2'b10);
        checkOutput("colOldData", bus.rsp_data, 36'h0AA);
        expMem[7] = 36'h123;
        applyStimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd0);
        checkOutput("colNewValid", bus.rsp_valid, 2'b10);
        checkOutput("colNewData", bus.rsp_data, 36'h123);

        // Requester 0 alone streams reads of addrs 0..7 back to back.
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                applyStimulus(1'b1, 2'b00, 2'b01, 4'd0, 4'd0, 36'h0, 36'h0, k[AW-1:0], 4'd0);
                checkOutput("strRready", bus.rready, 2'b01);
            end else begin
                applyStimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd0);
            end
            if (k > 0) begin
                checkOutput("strRspValid", bus.rsp_valid, 2'b01);
                checkOutput("strRspData", bus.rsp_data, expMem[k-1]);
            end
        end

        // Read contention: requester 0 was granted last, so 1 wins first.
        applyStimulus(1'b1, 2'b00, 2'b11, 4'd0, 4'd0, 36'h0, 36'h0, 4'd2, 4'd9);
        checkOutput("rcGrant0", bus.rready, 2'b10);
        checkOutput("rcRa0", ramRa, 4'd9);
        applyStimulus(1'b1, 2'b00, 2'b11, 4'd0, 4'd0, 36'h0, 36'h0, 4'd2, 4'd9);
        checkOutput("rcGrant1", bus.rready, 2'b01);
        checkOutput("rcRa1", ramRa, 4'd2);
        checkOutput("rcRspValid0", bus.rsp_valid, 2'b10);
        checkOutput("rcRspData0", bus.rsp_data, expMem[9]);
        applyStimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd0);
        checkOutput("rcRspValid1", bus.rsp_valid, 2'b01);
        checkOutput("rcRspData1", bus.rsp_data, expMem[2]);

        // Reset while a read response is pending.
        applyStimulus(1'b1, 2'b00, 2'b01, 4'd0, 4'd0, 36'h0, 36'h0, 4'd4, 4'd0);
        checkOutput("mrRready", bus.rready, 2'b01);
        applyStimulus(1'b0, 2'b11, 2'b11, 4'd1, 4'd2, 36'h5, 36'h6, 4'd3, 4'd4);
        checkOutput("mrWready", bus.wready, 2'b00);
        checkOutput("mrRreadyOff", bus.rready, 2'b00);
        checkOutput("mrWce", ramWce, 1'b0);
        checkOutput("mrRce", ramRce, 1'b0);
        checkOutput("mrPendingRsp", bus.rsp_valid, 2'b01);
        applyStimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd0);
        checkOutput("mrRspDropped", bus.rsp_valid, 2'b00);
        checkOutput("mrInitDone", initDone, 1'b0);
        checkOutput("mrSweepWce", ramWce, 1'b1);
        checkOutput("mrSweepWa0", ramWa, 4'd0);
        for (int i = 1; i < 9; i++) begin
            applyStimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd0);
            checkOutput("mrSweepWa", ramWa, i[AW-1:0]);
        end

        // Reset again with the sweep counter at 9; the sweep must restart.
        applyStimulus(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd0);
        checkOutput("ms9Wce", ramWce, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 2'b01, 2'b01, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd0);
            checkOutput("msWce", ramWce, 1'b1);
            checkOutput("msWa", ramWa, i[AW-1:0]);
            checkOutput("msWready", bus.wready, 2'b00);
            checkOutput("msInitDone", initDone, 1'b0);
        end
        applyStimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 36'h0, 36'h0, 4'd0, 4'd0);
        checkOutput("msInitDoneHigh", initDone, 1'b1);
        checkOutput("msIdleWce", ramWce, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
